// File: rtl/bk_adder_pkg.sv
// Shared types, mode encodings and elaboration-time helpers for the
// pipelined Brent-Kung adder/subtractor.
package bk_adder_pkg;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  // One (generate, propagate) pair of the prefix network.
  typedef struct packed {
    logic g;
    logic p;
  } gp_t;

  // Ceiling log2, usable in parameter and localparam expressions.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

  // Prefix levels: log2(W) up-sweep levels plus log2(W)-1 down-sweep levels.
  function automatic int nlev(input int width);
    return 2 * clog2(width) - 1;
  endfunction

  // Registered prefix stages when a register follows every reg_every levels.
  function automatic int nstage(input int width, input int reg_every);
    return (nlev(width) + reg_every - 1) / reg_every;
  endfunction

endpackage

// File: rtl/bk_prefix_level.sv
// One level of the Brent-Kung prefix tree. Positions owned by this level
// combine with their partner SPAN bits below; every other position passes
// straight through. Purely combinational.
module bk_prefix_level
  import bk_adder_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int LEVEL   = 0,    // index within its own sweep
  parameter bit UPSWEEP = 1'b1
) (
  input  gp_t [WIDTH-1:0] prev,
  output gp_t [WIDTH-1:0] next
);

  // Up-sweep strides grow 1,2,4..; down-sweep strides shrink W/4..1.
  localparam int SPAN = UPSWEEP ? (1 << LEVEL) : (WIDTH >> (LEVEL + 2));

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    // Up-sweep owns the top bit of each aligned 2*SPAN block; down-sweep
    // owns the mid points that the up-sweep left unresolved.
    localparam bit OWN = UPSWEEP ? (((i + 1) % (2 * SPAN)) == 0)
                                 : ((((i + 1) % (2 * SPAN)) == SPAN) && ((i + 1) > SPAN));
    if (OWN) begin : g_op
      assign next[i].g = prev[i].g | (prev[i].p & prev[i-SPAN].g);
      assign next[i].p = prev[i].p & prev[i-SPAN].p;
    end else begin : g_pass
      assign next[i] = prev[i];
    end
  end

endmodule

// File: rtl/bk_adder_pipe.sv
// Pipelined Brent-Kung adder/subtractor with valid/ready streaming.
// Stage 0 registers conditioned G/P; K prefix stages follow, the last of
// which produces the registered sum, carry-out and signed overflow.
// The whole pipeline advances together whenever the output can move.
module bk_adder_pipe
  import bk_adder_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int REG_EVERY = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int LOG2W = clog2(WIDTH);
  localparam int NLEV  = nlev(WIDTH);
  localparam int K     = nstage(WIDTH, REG_EVERY);

  logic advance;

  logic [WIDTH-1:0] b_eff;
  logic             c0_eff;
  gp_t  [WIDTH-1:0] gp_new;

  // Per-stage state: prefix pairs, original propagate (for the sum),
  // carry-in, operand sign bits and the valid bit.
  gp_t  [WIDTH-1:0] st_gp [K];
  logic [WIDTH-1:0] st_p  [K];
  logic [K-1:0]     st_c0;
  logic [K-1:0]     st_sa;
  logic [K-1:0]     st_sb;
  logic [K-1:0]     st_v;

  gp_t  [WIDTH-1:0] root;
  gp_t  [WIDTH-1:0] lvl_in  [NLEV];
  gp_t  [WIDTH-1:0] lvl_out [NLEV];

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_nxt;
  logic             ovf_nxt;

  // Output can move when empty or being consumed; everything shifts with it.
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // Condition operands: subtraction is a + ~b + 1.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    b_eff  = in_b;
    c0_eff = in_cin;
    gp_new = '0;
    if (in_mode == MODE_SUB) begin
      b_eff  = ~in_b;
      c0_eff = 1'b1;
    end
    for (int i = 0; i < WIDTH; i++) begin
      gp_new[i].g = in_a[i] & b_eff[i];
      gp_new[i].p = in_a[i] ^ b_eff[i];
    end
  end

  // Stage registers and valid chain, all shifting together on advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the pipeline data registers are cleared too, so the tree
      // never sees X after reset and bubbles stay deterministic.
      for (int s = 0; s < K; s++) begin
        st_gp[s] <= '0;
        st_p[s]  <= '0;
      end
      st_c0 <= '0;
      st_sa <= '0;
      st_sb <= '0;
      st_v  <= '0;
    end else if (advance) begin
      // NOTE: sequential state uses non-blocking assignments so every stage
      // reads its predecessor's pre-edge value and the shift is order-free.
      st_gp[0] <= gp_new;
      st_p[0]  <= in_a ^ b_eff;
      st_c0[0] <= c0_eff;
      st_sa[0] <= in_a[WIDTH-1];
      st_sb[0] <= b_eff[WIDTH-1];
      st_v[0]  <= in_valid;
      for (int s = 1; s < K; s++) begin
        st_gp[s] <= lvl_out[s*REG_EVERY-1];
        st_p[s]  <= st_p[s-1];
        st_c0[s] <= st_c0[s-1];
        st_sa[s] <= st_sa[s-1];
        st_sb[s] <= st_sb[s-1];
        st_v[s]  <= st_v[s-1];
      end
    end
  end

  // Fold carry-in into bit 0 so the tree yields c1..cW directly.
  always_comb begin
    root      = st_gp[0];
    root[0].g = st_gp[0][0].g | (st_gp[0][0].p & st_c0[0]);
  end

  // Chain the levels; a stage register restarts the chain every REG_EVERY.
  for (genvar l = 0; l < NLEV; l++) begin : g_lvl
    if (l == 0) begin : g_root
      assign lvl_in[l] = root;
    end else if ((l % REG_EVERY) == 0) begin : g_reg
      assign lvl_in[l] = st_gp[l/REG_EVERY];
    end else begin : g_comb
      assign lvl_in[l] = lvl_out[l-1];
    end

    bk_prefix_level #(
      .WIDTH   (WIDTH),
      .LEVEL   ((l < LOG2W) ? l : (l - LOG2W)),
      .UPSWEEP (l < LOG2W)
    ) u_level (
      .prev (lvl_in[l]),
      .next (lvl_out[l])
    );
  end

  // Final group: carries from the tree, sum bits and signed overflow.
  // Overflow via sign bits is equivalent to cW ^ c(W-1).
  always_comb begin
    carry[0] = st_c0[K-1];
    for (int i = 0; i < WIDTH; i++) carry[i+1] = lvl_out[NLEV-1][i].g;
    sum_nxt = st_p[K-1] ^ carry[WIDTH-1:0];
    ovf_nxt = (st_sa[K-1] ~^ st_sb[K-1]) & (st_sa[K-1] ^ sum_nxt[WIDTH-1]);
  end

  // Output register; holds while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_cout  <= 1'b0;
      out_ovf   <= 1'b0;
    end else if (advance) begin
      out_valid <= st_v[K-1];
      out_sum   <= sum_nxt;
      out_cout  <= carry[WIDTH];
      out_ovf   <= ovf_nxt;
    end
  end

endmodule

// File: tb/tb_bk_adder_pipe.sv
// Bench for bk_adder_pipe: directed reset, carry, subtract, backpressure and
// mid-flight reset scenarios, then a randomized stream against an
// arithmetic reference model with an in-order scoreboard.
module tb_bk_adder_pipe #(
  parameter int WIDTH     = 32,
  parameter int REG_EVERY = 3
);

  localparam int LOG2W = $clog2(WIDTH);
  localparam int LAT   = 1 + ((2 * LOG2W - 1) + REG_EVERY - 1) / REG_EVERY;
  localparam int NRAND = 10000;

  localparam logic MADD = 1'b0;
  localparam logic MSUB = 1'b1;

  localparam logic [WIDTH-1:0] ALL1 = '1;
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] MAXP = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MINN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic             in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_ovf;

  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];

  bk_adder_pipe #(.WIDTH(WIDTH), .REG_EVERY(REG_EVERY)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: integer sum of a, the effective b and the carry-in; overflow
  // from a one-bit sign extension of the signed sum.
  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic cin, input logic mode);
    logic [WIDTH-1:0] bb;
    logic             c0;
    logic [WIDTH:0]   u;
    logic [WIDTH:0]   s;
    exp_t             e;
    bb = (mode == MSUB) ? ~b : b;
    c0 = (mode == MSUB) ? 1'b1 : cin;
    u  = {1'b0, a} + {1'b0, bb} + {{WIDTH{1'b0}}, c0};
    s  = {a[WIDTH-1], a} + {bb[WIDTH-1], bb} + {{WIDTH{1'b0}}, c0};
    e.sum  = u[WIDTH-1:0];
    e.cout = u[WIDTH];
    e.ovf  = s[WIDTH] ^ s[WIDTH-1];
    return e;
  endfunction

  function automatic logic [WIDTH-1:0] rand_word();
    logic [WIDTH+31:0] t;
    int                k;
    t = '0;
    k = $urandom_range(0, 7);
    if (k == 0) return ALL1;
    if (k == 1) return '0;
    if (k == 2) return MINN;
    repeat ((WIDTH + 31) / 32) t = {t[WIDTH-1:0], 32'($urandom())};
    return t[WIDTH-1:0];
  endfunction

  function automatic exp_t observed();
    exp_t o;
    o.sum  = out_sum;
    o.cout = out_cout;
    o.ovf  = out_ovf;
    return o;
  endfunction

  // One cycle: drive after the falling edge, then sample the handshake.
  // Accepted beats are pushed to the scoreboard; outputs stay readable
  // until the next rising edge.
  task automatic tick(input logic v, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input logic cin, input logic mode, input logic ordy,
                      output logic acc, output logic xfer);
    @(negedge clk);
    in_valid  = v;
    in_a      = a;
    in_b      = b;
    in_cin    = cin;
    in_mode   = mode;
    out_ready = ordy;
    #1;
    acc  = in_valid && in_ready && rst_n;
    xfer = out_valid && out_ready;
    if (acc) sb.push_back(model(a, b, cin, mode));
  endtask

  task automatic drain();
    logic acc, xfer;
    repeat (LAT + 3) tick(1'b0, '0, '0, 1'b0, MADD, 1'b1, acc, xfer);
    sb.delete();
  endtask

  task automatic test_reset();
    logic acc, xfer;
    int   stale;
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_a      = ALL1;
    in_b      = ONE;
    in_cin    = 1'b1;
    in_mode   = MADD;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    checks++; if (out_sum !== '0) begin errors++; $display("FAIL reset_sum: got %h want 0", out_sum); end
    checks++; if (out_cout !== 1'b0) begin errors++; $display("FAIL reset_cout: got %b want 0", out_cout); end
    checks++; if (out_ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", out_ovf); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", in_ready); end
    stale = 0;
    for (int c = 0; c < LAT + 2; c++) begin
      tick(1'b0, '0, '0, 1'b0, MADD, 1'b1, acc, xfer);
      if (out_valid !== 1'b0) stale++;
    end
    checks++; if (stale != 0) begin errors++; $display("FAIL reset_capture: %0d valid cycles from beats offered in reset, want 0", stale); end
  endtask

  task automatic test_carry_chain();
    logic             acc, xfer;
    logic [WIDTH-1:0] a;
    exp_t             want;
    int               lat;
    for (int k = 0; k < 2; k++) begin
      a    = (k == 0) ? ALL1 : MAXP;
      want = (k == 0) ? '{sum: '0, cout: 1'b1, ovf: 1'b0} : '{sum: MINN, cout: 1'b0, ovf: 1'b1};
      tick(1'b1, a, ONE, 1'b0, MADD, 1'b1, acc, xfer);
      checks++; if (!acc) begin errors++; $display("FAIL carry_accept%0d: got 0 want 1", k); end
      lat = 0;
      for (int t = 1; t <= LAT + 4 && lat == 0; t++) begin
        tick(1'b0, '0, '0, 1'b0, MADD, 1'b1, acc, xfer);
        if (out_valid) lat = t;
      end
      checks++; if (lat != LAT) begin errors++; $display("FAIL carry_latency%0d: got %0d want %0d", k, lat, LAT); end
      checks++;
      if (observed() !== want) begin
        errors++;
        $display("FAIL carry_value%0d: got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
                 k, out_sum, out_cout, out_ovf, want.sum, want.cout, want.ovf);
      end
    end
    drain();
  endtask

  task automatic test_sub();
    logic acc1, acc2, acc, xfer;
    exp_t want1, want2;
    int   first;
    want1 = '{sum: ALL1 - ONE, cout: 1'b0, ovf: 1'b0};
    want2 = '{sum: MAXP, cout: 1'b1, ovf: 1'b1};
    tick(1'b1, WIDTH'(5), WIDTH'(7), 1'b1, MSUB, 1'b1, acc1, xfer);
    tick(1'b1, MINN, ONE, 1'b0, MSUB, 1'b1, acc2, xfer);
    checks++; if (!(acc1 && acc2)) begin errors++; $display("FAIL sub_accept: got %b%b want 11", acc1, acc2); end
    first = 0;
    for (int t = 2; t <= LAT + 4 && first == 0; t++) begin
      tick(1'b0, '0, '0, 1'b0, MADD, 1'b1, acc, xfer);
      if (out_valid) first = t;
    end
    checks++; if (first != LAT) begin errors++; $display("FAIL sub_latency: got %0d want %0d", first, LAT); end
    checks++;
    if (observed() !== want1) begin
      errors++;
      $display("FAIL sub_5m7: got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
               out_sum, out_cout, out_ovf, want1.sum, want1.cout, want1.ovf);
    end
    tick(1'b0, '0, '0, 1'b0, MADD, 1'b1, acc, xfer);
    checks++;
    if (!out_valid || observed() !== want2) begin
      errors++;
      $display("FAIL sub_min_m1: got v=%b sum=%h cout=%b ovf=%b want v=1 sum=%h cout=%b ovf=%b",
               out_valid, out_sum, out_cout, out_ovf, want2.sum, want2.cout, want2.ovf);
    end
    drain();
  endtask

  task automatic test_backpressure();
    logic acc, xfer, ordy, held;
    exp_t hold_val, e;
    int   sent, got;
    sent = 0; got = 0; held = 1'b0; hold_val = '0;
    for (int c = 0; c < LAT + 40 && got < 8; c++) begin
      ordy = !(c >= LAT + 1 && c < LAT + 4);
      tick(sent < 8, WIDTH'(sent), WIDTH'(sent << 8), 1'b0, MADD, ordy, acc, xfer);
      if (!ordy && out_valid) begin
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready: got %b want 0 at cycle %0d", in_ready, c); end
        if (held) begin
          checks++;
          if (observed() !== hold_val) begin
            errors++;
            $display("FAIL bp_hold: got sum=%h want %h at cycle %0d", out_sum, hold_val.sum, c);
          end
        end
        held = 1'b1;
        hold_val = observed();
      end else begin
        held = 1'b0;
      end
      if (acc) sent++;
      if (xfer) begin
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL bp_order: unexpected result sum=%h", out_sum);
        end else begin
          e = sb.pop_front();
          if (observed() !== e) begin
            errors++;
            $display("FAIL bp_data%0d: got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
                     got, out_sum, out_cout, out_ovf, e.sum, e.cout, e.ovf);
          end
        end
        got++;
      end
    end
    checks++; if (got != 8 || sb.size() != 0) begin errors++; $display("FAIL bp_count: got %0d results, %0d pending, want 8 and 0", got, sb.size()); end
    drain();
  endtask

  task automatic test_reset_midflight();
    logic acc, xfer, seen;
    exp_t e;
    int   sent, stale, lat;
    sent = 0;
    for (int c = 0; c < 20 && sent < 3; c++) begin
      tick(1'b1, rand_word(), rand_word(), 1'($urandom()), 1'($urandom()), 1'b1, acc, xfer);
      if (acc) sent++;
    end
    seen = 1'b0;
    for (int c = 0; c < LAT + 4 && !seen; c++) begin
      if (out_valid) seen = 1'b1;
      else tick(1'b0, '0, '0, 1'b0, MADD, 1'b0, acc, xfer);
    end
    checks++; if (!seen || sent != 3) begin errors++; $display("FAIL mid_setup: valid=%b accepted=%0d want 1 and 3", seen, sent); end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_sum !== '0 || out_cout !== 1'b0 || out_ovf !== 1'b0) begin
      errors++;
      $display("FAIL mid_async_clear: got v=%b sum=%h cout=%b ovf=%b want all 0", out_valid, out_sum, out_cout, out_ovf);
    end
    #1 rst_n = 1'b1;
    sb.delete();
    stale = 0;
    for (int c = 0; c < LAT + 3; c++) begin
      tick(1'b0, '0, '0, 1'b0, MADD, 1'b1, acc, xfer);
      if (out_valid) stale++;
    end
    checks++; if (stale != 0) begin errors++; $display("FAIL mid_stale: got %0d valid cycles want 0", stale); end
    tick(1'b1, MAXP, ALL1, 1'b1, MADD, 1'b1, acc, xfer);
    lat = 0;
    for (int t = 1; t <= LAT + 4 && lat == 0; t++) begin
      tick(1'b0, '0, '0, 1'b0, MADD, 1'b1, acc, xfer);
      if (out_valid) lat = t;
    end
    checks++; if (lat != LAT) begin errors++; $display("FAIL mid_latency: got %0d want %0d", lat, LAT); end
    checks++;
    if (sb.size() != 1) begin
      errors++; $display("FAIL mid_value: got %0d pending beats want 1", sb.size());
    end else begin
      e = sb.pop_front();
      if (observed() !== e) begin
        errors++;
        $display("FAIL mid_value: got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
                 out_sum, out_cout, out_ovf, e.sum, e.cout, e.ovf);
      end
    end
    drain();
  endtask

  task automatic test_random();
    logic acc, xfer;
    exp_t e;
    int   sent, got, bad;
    sent = 0; got = 0; bad = 0;
    for (int c = 0; c < 6 * NRAND && got < NRAND; c++) begin
      tick((sent < NRAND) && ($urandom_range(0, 9) < 8), rand_word(), rand_word(),
           1'($urandom()), 1'($urandom()), $urandom_range(0, 3) != 0, acc, xfer);
      if (acc) sent++;
      if (xfer) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          if (bad++ < 10) $display("FAIL rand_extra: unexpected result sum=%h", out_sum);
        end else begin
          e = sb.pop_front();
          if (observed() !== e) begin
            errors++;
            if (bad++ < 10)
              $display("FAIL rand_data%0d: got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
                       got, out_sum, out_cout, out_ovf, e.sum, e.cout, e.ovf);
          end
        end
        got++;
      end
    end
    checks++; if (got != NRAND) begin errors++; $display("FAIL rand_count: got %0d results want %0d", got, NRAND); end
    drain();
  endtask

  initial begin
    test_reset();
    test_carry_chain();
    test_sub();
    test_backpressure();
    test_reset_midflight();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
